// File: rtl/byte_serializer_tx.sv
// -----------------------------------------------------------------------------
// byte_serializer_tx
//   Transmit end of a strobe-counted serial link. A word is accepted on a
//   valid/ready handshake, then shifted out one bit per bit period
//   (CLKS_PER_BIT cycles). A one-cycle strobe marks the middle of every bit
//   period so the receiver can count DATA_WIDTH strobe events per frame.
//   An optional idle gap of GAP_BITS bit periods follows every frame.
//
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high reset
//   in_data     : word to transmit
//   in_valid    : in_data valid
//   in_ready    : block can accept a word (combinational: IDLE and not reset)
//   tx_data     : serial data line
//   tx_strobe   : one-cycle pulse at the middle of each bit period
//   tx_frame    : high while frame bits are on tx_data
//   busy        : high in any state other than IDLE
//   done        : one-cycle pulse after the last bit period
//   frames_sent : completed frames, saturating
// -----------------------------------------------------------------------------
module byte_serializer_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int MSB_FIRST    = 0,
  parameter int GAP_BITS     = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx_data,
  output logic                  tx_strobe,
  output logic                  tx_frame,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);

  localparam int IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DIV_W   = $clog2(CLKS_PER_BIT);
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(CLKS_PER_BIT / 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DIV_W-1:0]      r_div;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [CNT_WIDTH-1:0]  r_frames;
  logic                  r_tx_data, r_strobe, r_frame, r_busy, r_done;

  logic                  w_accept, w_frame_end, w_gap_end;
  logic                  w_bit_end, w_last_bit;
  logic [DIV_W-1:0]      w_div_nxt;
  logic [DATA_WIDTH-1:0] w_shift_adv;
  logic                  w_first_bit, w_next_bit;

  assign w_bit_end  = (r_div == DIV_LAST);
  assign w_last_bit = (r_bit_idx == IDX_LAST);
  assign w_div_nxt  = w_bit_end ? '0 : r_div + DIV_W'(1);

  // The bit currently on the line always sits at the output end of r_shift;
  // advancing shifts the next bit into that position.
  assign w_shift_adv = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
  assign w_next_bit  = (MSB_FIRST != 0) ? w_shift_adv[DATA_WIDTH-1] : w_shift_adv[0];
  assign w_first_bit = (MSB_FIRST != 0) ? in_data[DATA_WIDTH-1] : in_data[0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control decodes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_frame_end = 1'b0;
    w_gap_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // in_ready is exactly "IDLE and not reset"; reset overrides the
        // registers anyway, so in_valid alone qualifies the accept here.
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_bit_end && w_last_bit) begin
          w_frame_end = 1'b1;
          w_state_nxt = (GAP_CYC > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_gap_end   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_div     <= '0;
      r_gap_cnt <= '0;
      r_frames  <= '0;
      r_tx_data <= 1'b0;
      r_strobe  <= 1'b0;
      r_frame   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift   <= in_data;
            r_bit_idx <= '0;
            r_div     <= '0;
            r_tx_data <= w_first_bit;
            r_frame   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_div <= w_div_nxt;
          if (w_frame_end) begin
            r_tx_data <= 1'b0;
            r_frame   <= 1'b0;
            r_done    <= 1'b1;
            // Without a gap we land in IDLE, so busy drops in the done cycle.
            r_busy    <= (GAP_CYC > 0);
            r_gap_cnt <= '0;
            if (r_frames != {CNT_WIDTH{1'b1}})
              r_frames <= r_frames + CNT_WIDTH'(1);
          end else begin
            // Strobe is registered, so it is set from the div value the next
            // cycle will carry; this places it in the cycle where div==MID.
            r_strobe <= (w_div_nxt == DIV_MID);
            if (w_bit_end) begin
              r_shift   <= w_shift_adv;
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_tx_data <= w_next_bit;
            end
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          if (w_gap_end) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE) && !reset;
  assign tx_data     = r_tx_data;
  assign tx_strobe   = r_strobe;
  assign tx_frame    = r_frame;
  assign busy        = r_busy;
  assign done        = r_done;
  assign frames_sent = r_frames;

endmodule
